// File: rtl/spi_resp_regfile.sv
// SPI mode-0 responder: command byte selects a register and direction, data bytes
// then write the 32x8 register file or read it back; one address reads a host-fed FIFO.
//
// state | meaning
// IDLE  | select high or not yet seen falling; spi_miso held 0
// CMD   | shifting in the command byte, shifting out status_i
// DATA  | shifting data bytes for the decoded register and direction
module spi_resp_regfile #(
    parameter int FIFO_DEPTH  = 8,
    parameter int FIFO_REG    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset_n,
    input  logic                          spi_sclk,
    input  logic                          spi_mosi,
    input  logic                          spi_ss_n,
    output logic                          spi_miso,
    input  logic [7:0]                    status_i,
    input  logic [7:0]                    fifo_wdata,
    input  logic                          fifo_wvalid,
    output logic                          fifo_wready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          reg_wr_valid,
    output logic [4:0]                    reg_wr_addr,
    output logic [7:0]                    reg_wr_data
);

    localparam int               PW        = $clog2(FIFO_DEPTH);
    localparam int               CW        = PW + 1;
    localparam logic [4:0]       FIFO_ADDR = 5'(FIFO_REG);
    localparam logic [CW-1:0]    FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic                   sclk_prev_q, ss_prev_q;
    logic                   sclk_s, mosi_s, ss_s;
    logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  shift_in_q, shift_in_d;
    logic [7:0]  shift_out_q, shift_out_d;
    logic [7:0]  tx_buf_q, tx_buf_d;
    logic        tx_from_fifo_q, tx_from_fifo_d;
    logic        load_pend_q, load_pend_d;
    logic [4:0]  addr_q, addr_d;
    logic        dir_q, dir_d;
    logic        wr_valid_q, wr_valid_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [7:0]  byte_in;
    logic [7:0]  rd_src;
    logic        rf_we;

    logic [7:0]  regfile_q [0:31];
    logic [7:0]  regfile_d [0:31];

    logic [7:0]    fifo_mem_q [0:FIFO_DEPTH-1];
    logic [7:0]    fifo_mem_d [0:FIFO_DEPTH-1];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          fifo_empty, fifo_full;
    logic          push, pop;

    always_comb begin
        sclk_sync_d[0] = spi_sclk;
        mosi_sync_d[0] = spi_mosi;
        ss_sync_d[0]   = spi_ss_n;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sclk_sync_d[i] = sclk_sync_q[i-1];
            mosi_sync_d[i] = mosi_sync_q[i-1];
            ss_sync_d[i]   = ss_sync_q[i-1];
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign ss_rise   = ss_s & ~ss_prev_q;
    assign ss_fall   = ~ss_s & ss_prev_q;

    assign byte_in    = {shift_in_q, mosi_s};
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign rd_src     = (addr_q == FIFO_ADDR) ? (fifo_empty ? 8'h00 : fifo_mem_q[rd_ptr_q])
                                              : regfile_q[addr_q];

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_in_d     = shift_in_q;
        shift_out_d    = shift_out_q;
        tx_buf_d       = tx_buf_q;
        tx_from_fifo_d = tx_from_fifo_q;
        load_pend_d    = 1'b0;
        addr_d         = addr_q;
        dir_d          = dir_q;
        wr_valid_d     = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        rf_we          = 1'b0;
        pop            = 1'b0;

        // Next read byte is fetched one cycle after the byte boundary so a pop is already visible.
        if (load_pend_q) begin
            tx_buf_d       = rd_src;
            tx_from_fifo_d = (addr_q == FIFO_ADDR) && !fifo_empty;
        end

        case (state_q)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_d     = ST_CMD;
                    bit_cnt_d   = 3'd0;
                    shift_in_d  = 7'd0;
                    shift_out_d = status_i;
                end
            end
            ST_CMD: begin
                if (ss_rise) begin
                    state_d     = ST_IDLE;
                    shift_out_d = 8'h00;
                end else if (sclk_rise) begin
                    shift_in_d = byte_in[6:0];
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_DATA;
                        addr_d  = byte_in[7:3];
                        dir_d   = byte_in[1];
                        if (byte_in[1]) begin
                            tx_buf_d       = 8'h00;
                            tx_from_fifo_d = 1'b0;
                        end else begin
                            load_pend_d = 1'b1;
                        end
                    end
                end else if (sclk_fall) begin
                    shift_out_d = {shift_out_q[6:0], 1'b0};
                end
            end
            ST_DATA: begin
                if (ss_rise) begin
                    state_d        = ST_IDLE;
                    shift_out_d    = 8'h00;
                    tx_from_fifo_d = 1'b0;
                end else if (sclk_rise) begin
                    shift_in_d = byte_in[6:0];
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (dir_q) begin
                            wr_valid_d = 1'b1;
                            wr_addr_d  = addr_q;
                            wr_data_d  = byte_in;
                            rf_we      = (addr_q != FIFO_ADDR);
                        end else begin
                            pop         = tx_from_fifo_q;
                            load_pend_d = 1'b1;
                        end
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt_q == 3'd0) shift_out_d = tx_buf_q;
                    else                   shift_out_d = {shift_out_q[6:0], 1'b0};
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        regfile_d = regfile_q;
        if (rf_we) regfile_d[addr_q] = byte_in;
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign fifo_wready = !fifo_full || pop;
    assign push        = fifo_wvalid && fifo_wready;

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = fifo_wdata;
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sclk_sync_q    <= '0;
            mosi_sync_q    <= '0;
            // Select treated as low at reset so one already low at release never looks like a fall.
            ss_sync_q      <= '0;
            sclk_prev_q    <= 1'b0;
            ss_prev_q      <= 1'b0;
            state_q        <= ST_IDLE;
            bit_cnt_q      <= 3'd0;
            shift_in_q     <= 7'd0;
            shift_out_q    <= 8'h00;
            tx_buf_q       <= 8'h00;
            tx_from_fifo_q <= 1'b0;
            load_pend_q    <= 1'b0;
            addr_q         <= 5'd0;
            dir_q          <= 1'b0;
            wr_valid_q     <= 1'b0;
            wr_addr_q      <= 5'd0;
            wr_data_q      <= 8'h00;
            for (int i = 0; i < 32; i++) regfile_q[i] <= 8'h00;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= 8'h00;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            sclk_sync_q    <= sclk_sync_d;
            mosi_sync_q    <= mosi_sync_d;
            ss_sync_q      <= ss_sync_d;
            sclk_prev_q    <= sclk_s;
            ss_prev_q      <= ss_s;
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_in_q     <= shift_in_d;
            shift_out_q    <= shift_out_d;
            tx_buf_q       <= tx_buf_d;
            tx_from_fifo_q <= tx_from_fifo_d;
            load_pend_q    <= load_pend_d;
            addr_q         <= addr_d;
            dir_q          <= dir_d;
            wr_valid_q     <= wr_valid_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            regfile_q      <= regfile_d;
            fifo_mem_q     <= fifo_mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
        end
    end

    assign spi_miso     = (state_q != ST_IDLE) && shift_out_q[7];
    assign fifo_count   = count_q;
    assign reg_wr_valid = wr_valid_q;
    assign reg_wr_addr  = wr_addr_q;
    assign reg_wr_data  = wr_data_q;

endmodule

// File: tb/tb_spi_resp_regfile.sv
// Directed bench for spi_resp_regfile: bit-banged SPI master, FIFO pusher and a
// write-strobe monitor, with hand-computed expectations.
module tb_spi_resp_regfile;

    logic       clk_clk = 1'b0;
    logic       reset_reset_n;
    logic       spi_sclk, spi_mosi, spi_ss_n, spi_miso;
    logic [7:0] status_i, fifo_wdata;
    logic       fifo_wvalid, fifo_wready;
    logic [3:0] fifo_count;
    logic       reg_wr_valid;
    logic [4:0] reg_wr_addr;
    logic [7:0] reg_wr_data;

    spi_resp_regfile #(.FIFO_DEPTH(8), .FIFO_REG(1), .SYNC_STAGES(2)) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .spi_sclk     (spi_sclk),
        .spi_mosi     (spi_mosi),
        .spi_ss_n     (spi_ss_n),
        .spi_miso     (spi_miso),
        .status_i     (status_i),
        .fifo_wdata   (fifo_wdata),
        .fifo_wvalid  (fifo_wvalid),
        .fifo_wready  (fifo_wready),
        .fifo_count   (fifo_count),
        .reg_wr_valid (reg_wr_valid),
        .reg_wr_addr  (reg_wr_addr),
        .reg_wr_data  (reg_wr_data)
    );

    always #5 clk_clk = ~clk_clk;

    localparam int HALF = 8;

    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          last_rise_cyc = 0;
    logic [12:0] stb_q[$];
    int          lat_q[$];
    logic [7:0]  rx;

    always @(posedge clk_clk) cyc <= cyc + 1;

    always @(negedge clk_clk) begin
        if (reg_wr_valid === 1'b1) begin
            stb_q.push_back({reg_wr_addr, reg_wr_data});
            lat_q.push_back(cyc - last_rise_cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    task automatic ss_low();
        spi_ss_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic ss_high();
        wait_clk(HALF);
        spi_ss_n = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rxb);
        rxb = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_mosi = tx[i];
            wait_clk(HALF);
            rxb[i] = spi_miso;
            spi_sclk = 1'b1;
            last_rise_cyc = cyc;
            wait_clk(HALF);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic push(input logic [7:0] d);
        fifo_wdata  = d;
        fifo_wvalid = 1'b1;
        wait_clk(1);
        fifo_wvalid = 1'b0;
    endtask

    initial begin
        reset_reset_n = 1'b1;
        spi_sclk = 1'b0; spi_mosi = 1'b0; spi_ss_n = 1'b1;
        status_i = 8'h00; fifo_wdata = 8'h00; fifo_wvalid = 1'b0;
        wait_clk(2);
        reset_reset_n = 1'b0;
        wait_clk(4);
        check("rst_miso", spi_miso, 0);
        check("rst_wready", fifo_wready, 1);
        check("rst_count", fifo_count, 0);
        check("rst_wr_valid", reg_wr_valid, 0);
        check("rst_wr_addr", reg_wr_addr, 0);
        check("rst_wr_data", reg_wr_data, 0);
        reset_reset_n = 1'b1;
        wait_clk(10);
        check("idle_miso", spi_miso, 0);
        check("idle_wready", fifo_wready, 1);
        check("idle_strobes", stb_q.size(), 0);

        // write to the FIFO register: strobe only, status returned during command
        status_i = 8'hA5;
        ss_low();
        xfer(8'h0A, 8, rx);
        check("t2_status", rx, 8'hA5);
        xfer(8'h3C, 8, rx);
        ss_high();
        check("t2_nstb", stb_q.size(), 1);
        check("t2_stb0", stb_q[0], {5'd1, 8'h3C});
        check("t2_latency", lat_q[0], 3);
        check("t2_rf1", dut.regfile_q[1], 8'h00);
        check("t2_count", fifo_count, 0);

        // two writes to reg 2, then read back
        ss_low();
        xfer(8'h12, 8, rx);
        xfer(8'h11, 8, rx);
        xfer(8'h22, 8, rx);
        ss_high();
        check("t3_nstb", stb_q.size(), 3);
        check("t3_stb1", stb_q[1], {5'd2, 8'h11});
        check("t3_stb2", stb_q[2], {5'd2, 8'h22});
        ss_low();
        xfer(8'h10, 8, rx);
        xfer(8'h00, 8, rx);
        ss_high();
        check("t3_read", rx, 8'h22);

        // fill FIFO, overflow push, drain plus one empty read
        for (int i = 1; i <= 8; i++) push(8'(i));
        check("t4_full_count", fifo_count, 8);
        check("t4_full_wready", fifo_wready, 0);
        push(8'h09);
        check("t4_ovf_count", fifo_count, 8);
        ss_low();
        xfer(8'h08, 8, rx);
        for (int i = 0; i < 9; i++) begin
            xfer(8'h00, 8, rx);
            check($sformatf("t4_pop%0d", i), rx, (i < 8) ? 8'(i + 1) : 8'h00);
        end
        ss_high();
        check("t4_empty_count", fifo_count, 0);
        check("t4_nstb", stb_q.size(), 3);

        // push held across the pop of a full FIFO
        for (int i = 1; i <= 8; i++) push(8'(i));
        ss_low();
        xfer(8'h08, 8, rx);
        fifo_wdata  = 8'h55;
        fifo_wvalid = 1'b1;
        xfer(8'h00, 8, rx);
        check("t5_head", rx, 8'h01);
        wait_clk(2);
        fifo_wvalid = 1'b0;
        check("t5_count", fifo_count, 8);
        ss_high();
        ss_low();
        xfer(8'h08, 8, rx);
        for (int i = 0; i < 8; i++) begin
            xfer(8'h00, 8, rx);
            check($sformatf("t5_pop%0d", i), rx, (i < 7) ? 8'(i + 2) : 8'h55);
        end
        ss_high();
        check("t5_drained", fifo_count, 0);

        // partial write byte is discarded
        ss_low();
        xfer(8'h1A, 8, rx);
        xfer(8'hFF, 5, rx);
        ss_high();
        check("t6_nstb_partial", stb_q.size(), 3);
        ss_low();
        xfer(8'h18, 8, rx);
        xfer(8'h00, 8, rx);
        ss_high();
        check("t6_rf3_zero", rx, 8'h00);
        ss_low();
        xfer(8'h1A, 8, rx);
        xfer(8'h77, 8, rx);
        ss_high();
        check("t6_nstb", stb_q.size(), 4);
        check("t6_stb3", stb_q[3], {5'd3, 8'h77});
        ss_low();
        xfer(8'h18, 8, rx);
        xfer(8'h00, 8, rx);
        ss_high();
        check("t6_read", rx, 8'h77);

        // reset in the middle of a read with select held low
        push(8'h99);
        check("t7_count_pre", fifo_count, 1);
        status_i = 8'hC3;
        ss_low();
        xfer(8'h10, 8, rx);
        check("t7_status", rx, 8'hC3);
        xfer(8'h00, 4, rx);
        check("t7_partial", rx, 8'h20);
        reset_reset_n = 1'b0;
        wait_clk(2);
        check("t7_rst_miso", spi_miso, 0);
        check("t7_rst_count", fifo_count, 0);
        check("t7_rst_wready", fifo_wready, 1);
        check("t7_rst_wr_addr", reg_wr_addr, 0);
        check("t7_rst_wr_data", reg_wr_data, 0);
        reset_reset_n = 1'b1;
        wait_clk(4);
        xfer(8'h12, 8, rx);
        check("t7_dead_miso", rx, 8'h00);
        xfer(8'hEE, 8, rx);
        check("t7_dead_nstb", stb_q.size(), 4);
        check("t7_dead_miso_idle", spi_miso, 0);
        ss_high();
        ss_low();
        xfer(8'h10, 8, rx);
        check("t7_alive_status", rx, 8'hC3);
        xfer(8'h00, 8, rx);
        ss_high();
        check("t7_rf2_reset", rx, 8'h00);
        check("t7_final_nstb", stb_q.size(), 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
